// File: rtl/bram_tile_store_if.sv
// rtl/bram_tile_store_if.sv - result-line stream into the tile store
//
// Purpose : carries 256-bit result lines from the producer to bram_tile_store.
// Signals : din_valid - line available on din (producer)
//           din       - result line, word j = din[32j+31:32j] (producer)
//           din_ready - store accepts din this cycle (store)
// Modports: master = producer side, slave = store side.
interface bram_tile_store_if #(
    parameter int DATA_WIDTH = 256
);
    logic                  din_valid;
    logic [DATA_WIDTH-1:0] din;
    logic                  din_ready;

    modport master (
        output din_valid,
        output din,
        input  din_ready
    );

    modport slave (
        input  din_valid,
        input  din,
        output din_ready
    );
endinterface

// File: rtl/bram_tile_store.sv
// rtl/bram_tile_store.sv - serializes 256-bit result lines into 32-bit BRAM port-A writes
//
// Purpose : per start_store_i, accepts NUM_LINES_PER_TILE lines and writes each
//           as eight consecutive words at {line_ptr + line_cnt, word_idx}, the
//           same placement the fetch unit reads back as whole lines on port B.
// Ports   : clk, rst_n            - clock, asynchronous active-low reset
//           start_store_i         - 1-cycle pulse, begins a tile when idle
//           reset_addr_counter_i  - reload line pointer to STORE_START_OFFSET (idle only)
//           din_if (slave)        - din_valid / din / din_ready line stream
//           ena_o, wea_o          - BRAM port-A enable / write enable
//           addra_o, dina_o       - BRAM port-A word address / write data
//           store_done_o          - 1-cycle pulse after the last word of a tile
//           busy_o                - high whenever not IDLE
//           line_ptr_o            - current tile base line
module bram_tile_store #(
    parameter int NUM_LINES_PER_TILE = 32,
    parameter int LINE_ADDR_WIDTH    = 11,
    parameter int STORE_START_OFFSET = 112,
    parameter int WORD_WIDTH         = 32,
    parameter int DATA_WIDTH         = 8 * WORD_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_store_i,
    input  logic                       reset_addr_counter_i,
    bram_tile_store_if.slave           din_if,
    output logic                       ena_o,
    output logic                       wea_o,
    output logic [LINE_ADDR_WIDTH+2:0] addra_o,
    output logic [WORD_WIDTH-1:0]      dina_o,
    output logic                       store_done_o,
    output logic                       busy_o,
    output logic [LINE_ADDR_WIDTH-1:0] line_ptr_o
);
    // line_cnt must reach NUM_LINES_PER_TILE after the final increment
    localparam int LCW = $clog2(NUM_LINES_PER_TILE + 1);
    localparam logic [LCW-1:0]             LAST_LINE = LCW'(NUM_LINES_PER_TILE - 1);
    localparam logic [LINE_ADDR_WIDTH-1:0] OFFSET    = LINE_ADDR_WIDTH'(STORE_START_OFFSET);
    localparam logic [LINE_ADDR_WIDTH-1:0] TILE_STEP = LINE_ADDR_WIDTH'(NUM_LINES_PER_TILE);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LINE = 2'd1,
        WRITE     = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t                              state_q;
    logic [LCW-1:0]                      line_cnt_q;
    logic [2:0]                          word_idx_q;
    logic [7:0][WORD_WIDTH-1:0]          hold_q;
    logic [LINE_ADDR_WIDTH-1:0]          line_ptr_q;
    logic                                din_ready_q;
    logic                                ena_q;
    logic                                wea_q;
    logic [LINE_ADDR_WIDTH+2:0]          addra_q;
    logic [WORD_WIDTH-1:0]               dina_q;
    logic                                store_done_q;
    logic                                busy_q;

    // Line being written; wraps naturally modulo 2^LINE_ADDR_WIDTH.
    logic [LINE_ADDR_WIDTH-1:0] cur_line_d;
    logic [2:0]                 word_idx_d;

    always_comb begin
        cur_line_d = line_ptr_q + LINE_ADDR_WIDTH'(line_cnt_q);
        word_idx_d = word_idx_q + 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            line_cnt_q   <= '0;
            word_idx_q   <= '0;
            hold_q       <= '0;
            line_ptr_q   <= OFFSET;
            din_ready_q  <= 1'b0;
            ena_q        <= 1'b0;
            wea_q        <= 1'b0;
            addra_q      <= '0;
            dina_q       <= '0;
            store_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // The reload lands in the same edge as the start, so a
                    // combined request begins the tile at the offset.
                    if (reset_addr_counter_i) begin
                        line_ptr_q <= OFFSET;
                    end
                    if (start_store_i) begin
                        state_q     <= WAIT_LINE;
                        line_cnt_q  <= '0;
                        din_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end

                WAIT_LINE: begin
                    // Word 0 is issued straight from din so the first write
                    // appears the cycle after the handshake.
                    if (din_if.din_valid && din_ready_q) begin
                        hold_q      <= din_if.din;
                        word_idx_q  <= 3'd0;
                        din_ready_q <= 1'b0;
                        ena_q       <= 1'b1;
                        wea_q       <= 1'b1;
                        addra_q     <= {cur_line_d, 3'd0};
                        dina_q      <= din_if.din[WORD_WIDTH-1:0];
                        state_q     <= WRITE;
                    end
                end

                WRITE: begin
                    // word_idx_q is the word currently on the port.
                    if (word_idx_q == 3'd7) begin
                        ena_q      <= 1'b0;
                        wea_q      <= 1'b0;
                        line_cnt_q <= line_cnt_q + LCW'(1);
                        if (line_cnt_q == LAST_LINE) begin
                            state_q      <= DONE;
                            store_done_q <= 1'b1;
                            line_ptr_q   <= line_ptr_q + TILE_STEP;
                        end else begin
                            state_q     <= WAIT_LINE;
                            din_ready_q <= 1'b1;
                        end
                    end else begin
                        word_idx_q <= word_idx_d;
                        addra_q    <= {cur_line_d, word_idx_d};
                        dina_q     <= hold_q[word_idx_d];
                    end
                end

                DONE: begin
                    store_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign din_if.din_ready = din_ready_q;
    assign ena_o            = ena_q;
    assign wea_o            = wea_q;
    assign addra_o          = addra_q;
    assign dina_o           = dina_q;
    assign store_done_o     = store_done_q;
    assign busy_o           = busy_q;
    assign line_ptr_o       = line_ptr_q;
endmodule

// File: tb/tb_bram_tile_store.sv
// tb/tb_bram_tile_store.sv - scoreboard bench for bram_tile_store
module tb_bram_tile_store;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start[2];
    logic        rac[2];
    logic        dvalid[2];
    logic [255:0] ddata[2];
    logic        dready[2];
    logic        ena[2];
    logic        wea[2];
    logic [13:0] addra[2];
    logic [31:0] dina[2];
    logic        store_done[2];
    logic        busy[2];
    logic [10:0] lp[2];

    always #5 clk = ~clk;

    bram_tile_store_if #(.DATA_WIDTH(256)) if0 ();
    bram_tile_store_if #(.DATA_WIDTH(256)) if1 ();

    assign if0.din_valid = dvalid[0];
    assign if0.din       = ddata[0];
    assign dready[0]     = if0.din_ready;
    assign if1.din_valid = dvalid[1];
    assign if1.din       = ddata[1];
    assign dready[1]     = if1.din_ready;

    bram_tile_store dut0 (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start_store_i        (start[0]),
        .reset_addr_counter_i (rac[0]),
        .din_if               (if0),
        .ena_o                (ena[0]),
        .wea_o                (wea[0]),
        .addra_o              (addra[0]),
        .dina_o               (dina[0]),
        .store_done_o         (store_done[0]),
        .busy_o               (busy[0]),
        .line_ptr_o           (lp[0])
    );

    bram_tile_store #(.STORE_START_OFFSET(2040)) dut1 (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start_store_i        (start[1]),
        .reset_addr_counter_i (rac[1]),
        .din_if               (if1),
        .ena_o                (ena[1]),
        .wea_o                (wea[1]),
        .addra_o              (addra[1]),
        .dina_o               (dina[1]),
        .store_done_o         (store_done[1]),
        .busy_o               (busy[1]),
        .line_ptr_o           (lp[1])
    );

    int errors = 0;
    int checks = 0;
    int offset[2] = '{112, 2040};
    int model_ptr[2];
    int wr_cnt[2];
    int done_cnt[2];
    int run[2];
    logic prev_ena[2];
    logic prev_done[2];
    // {dut, addra, dina}
    logic [46:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds din_valid until the store accepts, then books the 8 expected writes.
    task automatic send_line(input int k, input int L, input int seed, output bit ok);
        logic [255:0] line;
        logic [13:0]  a;
        int t;
        bit hs;
        for (int j = 0; j < 8; j++) line[32*j +: 32] = 32'(seed + (8*L + j)*2 + 2);
        ddata[k]  = line;
        dvalid[k] = 1'b1;
        t = 0;
        hs = 1'b0;
        while (!hs && t < 60) begin
            @(negedge clk);
            hs = dready[k];
            tick();
            t++;
        end
        if (hs) begin
            for (int j = 0; j < 8; j++) begin
                a = 14'(((model_ptr[k] + L) % 2048) * 8 + j);
                exp_q.push_back({k[0], a, line[32*j +: 32]});
            end
        end else begin
            chk("handshake_timeout", 64'(t), 64'd0);
        end
        dvalid[k] = 1'b0;
        ok = hs;
    endtask

    task automatic run_tile(input int k, input int gap, input int seed, input bit with_rac);
        int d0, w0, t;
        bit ok;
        d0 = done_cnt[k];
        w0 = wr_cnt[k];
        if (with_rac) begin
            rac[k] = 1'b1;
            model_ptr[k] = offset[k];
        end
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
        rac[k]   = 1'b0;
        for (int L = 0; L < 32; L++) begin
            repeat (gap + (L % 3)) tick();
            send_line(k, L, seed, ok);
            if (!ok) return;
        end
        t = 0;
        while (!store_done[k] && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", 64'(store_done[k]), 64'd1);
        model_ptr[k] = (model_ptr[k] + 32) % 2048;
        chk("line_ptr_after_tile", 64'(lp[k]), 64'(model_ptr[k]));
        repeat (4) @(negedge clk);
        chk("writes_per_tile", 64'(wr_cnt[k] - w0), 64'd256);
        chk("dones_per_tile", 64'(done_cnt[k] - d0), 64'd1);
        chk("busy_after_tile", 64'(busy[k]), 64'd0);
    endtask

    // Write monitor: every enabled cycle must match the head of the scoreboard.
    initial begin
        logic [46:0] e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    run[k]       = 0;
                    prev_ena[k]  = 1'b0;
                    prev_done[k] = 1'b0;
                end else begin
                    if (ena[k]) begin
                        chk("wea_in_write", 64'(wea[k]), 64'd1);
                        if (exp_q.size() == 0) begin
                            chk("unexpected_write_addr", 64'(addra[k]), 64'hffff);
                        end else begin
                            e = exp_q.pop_front();
                            chk("wr_dut", 64'(k), 64'(e[46]));
                            chk("wr_addr", 64'(addra[k]), 64'(e[45:32]));
                            chk("wr_data", 64'(dina[k]), 64'(e[31:0]));
                        end
                        run[k]++;
                        wr_cnt[k]++;
                    end else begin
                        chk("wea_idle", 64'(wea[k]), 64'd0);
                        if (run[k] > 0) chk("burst_len", 64'(run[k]), 64'd8);
                        run[k] = 0;
                    end
                    if (store_done[k]) begin
                        done_cnt[k]++;
                        chk("done_single_pulse", 64'(prev_done[k]), 64'd0);
                        chk("done_after_last_write", 64'(prev_ena[k]), 64'd1);
                        chk("done_queue_empty", 64'(exp_q.size()), 64'd0);
                    end
                    prev_ena[k]  = ena[k];
                    prev_done[k] = store_done[k];
                end
            end
        end
    end

    initial begin
        int d0;
        bit ok;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; rac[k] = 1'b0; dvalid[k] = 1'b0; ddata[k] = '0;
            model_ptr[k] = offset[k]; wr_cnt[k] = 0; done_cnt[k] = 0; run[k] = 0;
            prev_ena[k] = 1'b0; prev_done[k] = 1'b0;
        end

        // Reset state
        repeat (5) tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_din_ready", 64'(dready[k]), 64'd0);
            chk("rst_ena", 64'(ena[k]), 64'd0);
            chk("rst_wea", 64'(wea[k]), 64'd0);
            chk("rst_addra", 64'(addra[k]), 64'd0);
            chk("rst_dina", 64'(dina[k]), 64'd0);
            chk("rst_store_done", 64'(store_done[k]), 64'd0);
            chk("rst_busy", 64'(busy[k]), 64'd0);
            chk("rst_line_ptr", 64'(lp[k]), 64'(offset[k]));
        end
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_no_ena", 64'(ena[0]), 64'd0);

        // Tile 1: din_valid held high, spec data pattern, lines 112..143
        run_tile(0, 0, 0, 1'b0);

        // Tile 2: din_valid gaps long enough to stall WAIT_LINE
        tick(); tick();
        run_tile(0, 10, 1000, 1'b0);

        // Wrap across the top of the line space
        run_tile(1, 0, 7000, 1'b0);

        // start_store and reset_addr_counter while busy are ignored
        fork
            run_tile(0, 0, 3000, 1'b0);
            begin
                repeat (100) tick();
                start[0] = 1'b1;
                rac[0]   = 1'b1;
                tick();
                start[0] = 1'b0;
                rac[0]   = 1'b0;
                chk("line_ptr_mid_tile", 64'(lp[0]), 64'(model_ptr[0]));
            end
        join

        // Reload and start together in IDLE: tile restarts at line 112
        tick();
        run_tile(0, 0, 4000, 1'b1);

        // Asynchronous reset during line 5, word 3
        d0 = done_cnt[0];
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        ok = 1'b1;
        for (int L = 0; L < 6 && ok; L++) send_line(0, L, 6000, ok);
        repeat (3) tick();
        chk("word3_addr_before_reset", 64'(addra[0]), 64'(((model_ptr[0] + 5) % 2048) * 8 + 3));
        rst_n = 1'b0;
        #1;
        chk("async_rst_ena", 64'(ena[0]), 64'd0);
        chk("async_rst_wea", 64'(wea[0]), 64'd0);
        chk("async_rst_busy", 64'(busy[0]), 64'd0);
        exp_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        model_ptr[0] = offset[0];
        chk("async_rst_line_ptr", 64'(lp[0]), 64'd112);
        repeat (20) tick();
        chk("no_done_after_reset", 64'(done_cnt[0] - d0), 64'd0);
        run_tile(0, 0, 8000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
